// File: rtl/cam_requester.sv
// Serialising initiator for the CAM port: one command in, one CAM strobe, one response out.
// Optional hit/miss counters are enabled by defining CAM_REQUESTER_STATS_EN.
module cam_requester #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CAM_LAT    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef CAM_REQUESTER_STATS_EN
    input  logic                  stats_clear_i,
    output logic [15:0]           hit_count_o,
    output logic [15:0]           miss_count_o,
`endif
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_index_i,
    input  logic [WIDTH-1:0]      cmd_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [1:0]            rsp_op_o,
    output logic                  rsp_hit_o,
    output logic                  rsp_err_o,
    output logic [WIDTH-1:0]      rsp_data_o,
    output logic [ADDR_WIDTH-1:0] rsp_index_o,
    output logic                  cam_read_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_read_index_o,
    output logic                  cam_write_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [WIDTH-1:0]      cam_write_data_o,
    output logic                  cam_search_enable_o,
    output logic [WIDTH-1:0]      cam_search_data_o,
    input  logic                  cam_read_valid_i,
    input  logic [WIDTH-1:0]      cam_read_value_i,
    input  logic                  cam_search_valid_i,
    input  logic [ADDR_WIDTH-1:0] cam_search_index_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_SE  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [3:0] LAT_M1 = 4'(CAM_LAT - 1);

    logic [1:0]            r_state;
    logic [1:0]            r_op;
    logic [3:0]            r_cnt;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [1:0]            r_rsp_op;
    logic                  r_rsp_hit;
    logic                  r_rsp_err;
    logic [WIDTH-1:0]      r_rsp_data;
    logic [ADDR_WIDTH-1:0] r_rsp_index;
    logic                  r_cam_re;
    logic [ADDR_WIDTH-1:0] r_cam_ri;
    logic                  r_cam_we;
    logic [ADDR_WIDTH-1:0] r_cam_wi;
    logic [WIDTH-1:0]      r_cam_wd;
    logic                  r_cam_se;
    logic [WIDTH-1:0]      r_cam_sd;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_op    <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_index <= '0;
            r_cam_re    <= 1'b0;
            r_cam_ri    <= '0;
            r_cam_we    <= 1'b0;
            r_cam_wi    <= '0;
            r_cam_wd    <= '0;
            r_cam_se    <= 1'b0;
            r_cam_sd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= cmd_op_i;
                        if (cmd_op_i == OP_RSV) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_op    <= cmd_op_i;
                            r_rsp_err   <= 1'b1;
                            r_rsp_hit   <= 1'b0;
                            r_rsp_data  <= '0;
                            r_rsp_index <= '0;
                        end else begin
                            // Strobe and bus registers double as the latched command.
                            r_state  <= S_ISSUE;
                            r_cam_re <= (cmd_op_i == OP_RD);
                            r_cam_ri <= (cmd_op_i == OP_RD) ? cmd_index_i : '0;
                            r_cam_we <= (cmd_op_i == OP_WR);
                            r_cam_wi <= (cmd_op_i == OP_WR) ? cmd_index_i : '0;
                            r_cam_wd <= (cmd_op_i == OP_WR) ? cmd_data_i : '0;
                            r_cam_se <= (cmd_op_i == OP_SE);
                            r_cam_sd <= (cmd_op_i == OP_SE) ? cmd_data_i : '0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cam_re <= 1'b0;
                    r_cam_ri <= '0;
                    r_cam_we <= 1'b0;
                    r_cam_wi <= '0;
                    r_cam_wd <= '0;
                    r_cam_se <= 1'b0;
                    r_cam_sd <= '0;
                    r_cnt    <= LAT_M1;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_op    <= r_op;
                        r_rsp_err   <= 1'b0;
                        r_rsp_hit   <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_index <= '0;
                        case (r_op)
                            OP_RD: begin
                                r_rsp_hit  <= cam_read_valid_i;
                                r_rsp_data <= cam_read_valid_i ? cam_read_value_i : '0;
                            end
                            OP_SE: begin
                                r_rsp_hit   <= cam_search_valid_i;
                                r_rsp_index <= cam_search_valid_i ? cam_search_index_i : '0;
                            end
                            default: r_rsp_hit <= 1'b1;
                        endcase
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        r_cmd_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_op    <= '0;
                        r_rsp_hit   <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_index <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o         = r_cmd_ready;
    assign rsp_valid_o         = r_rsp_valid;
    assign rsp_op_o            = r_rsp_op;
    assign rsp_hit_o           = r_rsp_hit;
    assign rsp_err_o           = r_rsp_err;
    assign rsp_data_o          = r_rsp_data;
    assign rsp_index_o         = r_rsp_index;
    assign cam_read_enable_o   = r_cam_re;
    assign cam_read_index_o    = r_cam_ri;
    assign cam_write_enable_o  = r_cam_we;
    assign cam_write_index_o   = r_cam_wi;
    assign cam_write_data_o    = r_cam_wd;
    assign cam_search_enable_o = r_cam_se;
    assign cam_search_data_o   = r_cam_sd;

`ifdef CAM_REQUESTER_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;
    logic        w_count_evt;

    // Only read and search responses carry a meaningful hit/miss outcome.
    assign w_count_evt = (r_state == S_RESP) && rsp_ready_i &&
                         ((r_rsp_op == OP_RD) || (r_rsp_op == OP_SE));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (stats_clear_i) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_count_evt) begin
            if (r_rsp_hit) begin
                if (r_hit_count != '1) r_hit_count <= r_hit_count + 16'd1;
            end else begin
                if (r_miss_count != '1) r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count_o  = r_hit_count;
    assign miss_count_o = r_miss_count;
`endif

endmodule

// File: tb/tb_cam_requester.sv
// Bench for cam_requester: two instances (CAM_LAT 1 and 4), each paired with a behavioural CAM,
// driven by directed and random commands checked against a transaction-level reference.
module tb_cam_requester;

    localparam int W  = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          cmd_valid [2];
    logic          cmd_ready [2];
    logic [1:0]    cmd_op    [2];
    logic [AW-1:0] cmd_index [2];
    logic [W-1:0]  cmd_data  [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic [1:0]    rsp_op    [2];
    logic          rsp_hit   [2];
    logic          rsp_err   [2];
    logic [W-1:0]  rsp_data  [2];
    logic [AW-1:0] rsp_index [2];
    logic          cam_re    [2];
    logic [AW-1:0] cam_ri    [2];
    logic          cam_we    [2];
    logic [AW-1:0] cam_wi    [2];
    logic [W-1:0]  cam_wd    [2];
    logic          cam_se    [2];
    logic [W-1:0]  cam_sd    [2];
`ifdef CAM_REQUESTER_STATS_EN
    logic          stats_clear [2];
    logic [15:0]   hit_cnt     [2];
    logic [15:0]   miss_cnt    [2];
    int            ref_hits    [2];
    int            ref_miss    [2];
`endif

    // Reference view of each CAM: what was written, and where.
    logic [W-1:0]  ref_mem [2][32];
    logic          ref_vld [2][32];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 4;

        logic [W-1:0]  mem [32] = '{default: '0};
        logic          vld [32] = '{default: 1'b0};
        logic          pend     = 1'b0;
        int            dly      = 0;
        logic          res_rv   = 1'b0;
        logic          res_sv   = 1'b0;
        logic [W-1:0]  res_val  = '0;
        logic [AW-1:0] res_si   = '0;
        logic          live;
        logic          m_rv;
        logic          m_sv;
        logic [W-1:0]  m_val;
        logic [AW-1:0] m_si;

        // Results appear only in the cycle LAT after the strobe; other cycles show inverted values.
        always @(posedge clk) begin
            if (cam_we[g]) begin
                mem[cam_wi[g]] <= cam_wd[g];
                vld[cam_wi[g]] <= 1'b1;
            end
            if (cam_re[g] || cam_se[g]) begin
                pend    <= 1'b1;
                dly     <= 1;
                res_rv  <= vld[cam_ri[g]];
                res_val <= mem[cam_ri[g]];
                res_sv  <= 1'b0;
                res_si  <= '0;
                for (int i = 31; i >= 0; i--) begin
                    if (vld[i] && mem[i] == cam_sd[g]) begin
                        res_sv <= 1'b1;
                        res_si <= AW'(i);
                    end
                end
            end else if (pend) begin
                if (dly == LAT) pend <= 1'b0;
                else dly <= dly + 1;
            end
        end

        assign live  = pend && (dly == LAT);
        assign m_rv  = live ? res_rv  : ~res_rv;
        assign m_val = live ? res_val : ~res_val;
        assign m_sv  = live ? res_sv  : ~res_sv;
        assign m_si  = live ? res_si  : ~res_si;

        cam_requester #(
            .WIDTH      (W),
            .ADDR_WIDTH (AW),
            .CAM_LAT    (LAT)
        ) u_dut (
            .clk_i               (clk),
            .rst_i               (rst_n),
`ifdef CAM_REQUESTER_STATS_EN
            .stats_clear_i       (stats_clear[g]),
            .hit_count_o         (hit_cnt[g]),
            .miss_count_o        (miss_cnt[g]),
`endif
            .cmd_valid_i         (cmd_valid[g]),
            .cmd_ready_o         (cmd_ready[g]),
            .cmd_op_i            (cmd_op[g]),
            .cmd_index_i         (cmd_index[g]),
            .cmd_data_i          (cmd_data[g]),
            .rsp_valid_o         (rsp_valid[g]),
            .rsp_ready_i         (rsp_ready[g]),
            .rsp_op_o            (rsp_op[g]),
            .rsp_hit_o           (rsp_hit[g]),
            .rsp_err_o           (rsp_err[g]),
            .rsp_data_o          (rsp_data[g]),
            .rsp_index_o         (rsp_index[g]),
            .cam_read_enable_o   (cam_re[g]),
            .cam_read_index_o    (cam_ri[g]),
            .cam_write_enable_o  (cam_we[g]),
            .cam_write_index_o   (cam_wi[g]),
            .cam_write_data_o    (cam_wd[g]),
            .cam_search_enable_o (cam_se[g]),
            .cam_search_data_o   (cam_sd[g]),
            .cam_read_valid_i    (m_rv),
            .cam_read_value_i    (m_val),
            .cam_search_valid_i  (m_sv),
            .cam_search_index_i  (m_si)
        );
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

`ifdef CAM_REQUESTER_STATS_EN
    task automatic check_stats(input int g);
        check("hit_count", 32'(hit_cnt[g]), 32'(ref_hits[g]));
        check("miss_count", 32'(miss_cnt[g]), 32'(ref_miss[g]));
    endtask
`endif

    task automatic check_reset_outputs(input int g);
        check("rst_cmd_ready", 32'(cmd_ready[g]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[g]), 32'd0);
        check("rst_strobes", 32'({cam_re[g], cam_we[g], cam_se[g]}), 32'd0);
        check("rst_rsp_fields", 32'({rsp_op[g], rsp_hit[g], rsp_err[g], rsp_index[g]}) | rsp_data[g], 32'd0);
`ifdef CAM_REQUESTER_STATS_EN
        ref_hits[g] = 0;
        ref_miss[g] = 0;
        check_stats(g);
`endif
    endtask

    task automatic run_cmd(input int g, input logic [1:0] op, input logic [AW-1:0] idx,
                           input logic [W-1:0] data, input int bp);
        int            lat, cyc, exp_rsp, n_rd, n_wr, n_se, str_cyc;
        logic          e_hit, e_err;
        logic [W-1:0]  e_data;
        logic [AW-1:0] e_idx;
        logic          do_clr;
        lat    = (g == 0) ? 1 : 4;
        e_hit  = 1'b0;
        e_err  = 1'b0;
        e_data = '0;
        e_idx  = '0;
        do_clr = 1'b0;
        case (op)
            2'b00: begin
                e_hit = ref_vld[g][idx];
                if (e_hit) e_data = ref_mem[g][idx];
            end
            2'b01: begin
                e_hit = 1'b1;
                ref_mem[g][idx] = data;
                ref_vld[g][idx] = 1'b1;
            end
            2'b10: begin
                for (int i = 31; i >= 0; i--)
                    if (ref_vld[g][i] && ref_mem[g][i] == data) begin
                        e_hit = 1'b1;
                        e_idx = AW'(i);
                    end
            end
            default: e_err = 1'b1;
        endcase
        exp_rsp = (op == 2'b11) ? 1 : 2 + lat;

        cyc = 0;
        while (!cmd_ready[g] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("cmd_ready_idle", 32'(cmd_ready[g]), 32'd1);
        cmd_valid[g] = 1'b1;
        cmd_op[g]    = op;
        cmd_index[g] = idx;
        cmd_data[g]  = data;
        rsp_ready[g] = (bp == 0);
        @(posedge clk); #1;
        // Garbage held on the command port while busy must be ignored.
        cmd_op[g]    = 2'($urandom);
        cmd_index[g] = AW'($urandom);
        cmd_data[g]  = $urandom;

        cyc = 1; n_rd = 0; n_wr = 0; n_se = 0; str_cyc = 0;
        while (!rsp_valid[g] && cyc < 40) begin
            check("cmd_ready_busy", 32'(cmd_ready[g]), 32'd0);
            if (cam_re[g]) begin
                n_rd++; str_cyc = cyc;
                check("rd_index", 32'(cam_ri[g]), 32'(idx));
            end
            if (cam_we[g]) begin
                n_wr++; str_cyc = cyc;
                check("wr_index", 32'(cam_wi[g]), 32'(idx));
                check("wr_data", cam_wd[g], data);
            end
            if (cam_se[g]) begin
                n_se++; str_cyc = cyc;
                check("se_key", cam_sd[g], data);
            end
            if (cam_re[g] || cam_we[g] || cam_se[g])
                check("unused_bus_zero", 32'((!cam_re[g] && cam_ri[g] != '0) ||
                      (!cam_we[g] && (cam_wi[g] != '0 || cam_wd[g] != '0)) ||
                      (!cam_se[g] && cam_sd[g] != '0)), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        check("rsp_latency", 32'(cyc), 32'(exp_rsp));
        check("rd_strobes", 32'(n_rd), 32'(op == 2'b00));
        check("wr_strobes", 32'(n_wr), 32'(op == 2'b01));
        check("se_strobes", 32'(n_se), 32'(op == 2'b10));
        if (op != 2'b11) check("strobe_cycle", 32'(str_cyc), 32'd1);
        check("rsp_fields", 32'({rsp_op[g], rsp_hit[g], rsp_err[g], rsp_index[g]}),
              32'({op, e_hit, e_err, e_idx}));
        check("rsp_data", rsp_data[g], e_data);

        for (int k = 0; k < bp; k++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(rsp_valid[g]), 32'd1);
            check("bp_fields", 32'({rsp_op[g], rsp_hit[g], rsp_err[g], rsp_index[g]}),
                  32'({op, e_hit, e_err, e_idx}));
            check("bp_data", rsp_data[g], e_data);
            check("bp_cmd_ready", 32'(cmd_ready[g]), 32'd0);
            check("bp_strobes", 32'({cam_re[g], cam_we[g], cam_se[g]}), 32'd0);
        end

        rsp_ready[g] = 1'b1;
`ifdef CAM_REQUESTER_STATS_EN
        do_clr = ($urandom_range(0, 7) == 0);
        stats_clear[g] = do_clr;
`endif
        @(posedge clk); #1;
        cmd_valid[g] = 1'b0;
        rsp_ready[g] = 1'b0;
`ifdef CAM_REQUESTER_STATS_EN
        stats_clear[g] = 1'b0;
        if (do_clr) begin
            ref_hits[g] = 0;
            ref_miss[g] = 0;
        end else if (op == 2'b00 || op == 2'b10) begin
            if (e_hit) ref_hits[g] = (ref_hits[g] < 65535) ? ref_hits[g] + 1 : 65535;
            else       ref_miss[g] = (ref_miss[g] < 65535) ? ref_miss[g] + 1 : 65535;
        end
        check_stats(g);
`endif
        if (do_clr) check("clear_flag", 32'(do_clr), 32'(do_clr));
        check("rsp_released", 32'(rsp_valid[g]), 32'd0);
        check("cmd_ready_back", 32'(cmd_ready[g]), 32'd1);
    endtask

    task automatic reset_mid_issue(input int g, input logic [W-1:0] key);
        int cyc;
        cyc = 0;
        while (!cmd_ready[g] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        cmd_valid[g] = 1'b1;
        cmd_op[g]    = 2'b10;
        cmd_data[g]  = key;
        @(posedge clk); #1;
        cmd_valid[g] = 1'b0;
        check("issue_search_strobe", 32'(cam_se[g]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_drops_strobe", 32'(cam_se[g]), 32'd0);
        check_reset_outputs(0);
        check_reset_outputs(1);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release0", 32'(cmd_ready[0]), 32'd1);
        check("ready_after_release1", 32'(cmd_ready[1]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]    op;
        logic [AW-1:0] idx;
        logic [W-1:0]  data;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            cmd_valid[g] = 1'b0;
            cmd_op[g]    = '0;
            cmd_index[g] = '0;
            cmd_data[g]  = '0;
            rsp_ready[g] = 1'b0;
`ifdef CAM_REQUESTER_STATS_EN
            stats_clear[g] = 1'b0;
`endif
            for (int i = 0; i < 32; i++) begin
                ref_mem[g][i] = '0;
                ref_vld[g][i] = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_first_edge0", 32'(cmd_ready[0]), 32'd1);
        check("ready_first_edge1", 32'(cmd_ready[1]), 32'd1);

        for (int g = 0; g < 2; g++) begin
            run_cmd(g, 2'b01, 5'd3, 32'hDEADBEEF, 0);
            run_cmd(g, 2'b00, 5'd3, 32'h0, 0);
            run_cmd(g, 2'b10, 5'd0, 32'hDEADBEEF, 0);
            run_cmd(g, 2'b10, 5'd0, 32'h12345678, 0);
            run_cmd(g, 2'b11, 5'd9, 32'hA5A5A5A5, 5);
            run_cmd(g, 2'b00, 5'd7, 32'h0, 0);
        end

        for (int n = 0; n < 80; n++) begin
            op   = 2'($urandom_range(0, 3));
            idx  = AW'($urandom_range(0, 7));
            data = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
            if (op == 2'b10 && $urandom_range(0, 1) == 1)
                data = ref_mem[n % 2][$urandom_range(0, 7)];
            run_cmd(n % 2, op, idx, data, int'($urandom_range(0, 3)));
        end

        reset_mid_issue(0, 32'hDEADBEEF);
        run_cmd(0, 2'b00, 5'd3, 32'h0, 0);
        reset_mid_issue(1, 32'h12345678);
        run_cmd(1, 2'b10, 5'd0, 32'hDEADBEEF, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
